// File: rtl/divider_iterative.sv
// divider_iterative: multi-cycle restoring divider, one quotient bit per cycle, signed mode under DIVIDER_SIGNED_EN
module divider_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, a_org, a_mag, b_mag, rem_n, dvd_n, q_fix, r_fix;
  logic [WIDTH:0] sh, diff;
  assign sh    = {rem, dvd[WIDTH-1]};
  assign diff  = sh - {1'b0, dvs};
  assign rem_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dvd_n = {dvd[WIDTH-2:0], ~diff[WIDTH]};
`ifdef DIVIDER_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  assign q_fix = q_neg ? -dvd_n : dvd_n;
  assign r_fix = r_neg ? -rem_n : rem_n;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_mag = a;
  assign b_mag = b;
  assign q_fix = dvd_n;
  assign r_fix = rem_n;
`endif
  // control FSM and datapath; a zero divisor magnitude means b was zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      a_org <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      q <= '0;
      r <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else if (state == RUN) begin
      rem <= rem_n;
      dvd <= dvd_n;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH-1)) begin
        q <= (dvs == '0) ? '1 : q_fix;
        r <= (dvs == '0) ? a_org : r_fix;
        div_by_zero <= (dvs == '0);
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else if (start) begin
      a_org <= a;
      dvd <= a_mag;
      dvs <= b_mag;
      rem <= '0;
      cnt <= '0;
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg <= is_signed && a[WIDTH-1];
`endif
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_divider_iterative.sv
// tb_divider_iterative: table-driven checks plus handshake corner sequences for divider_iterative
module tb_divider_iterative;
  logic clk = 0, reset, start, is_signed, busy, done, div_by_zero;
  logic [31:0] a, b, q, r;
  int n_chk = 0, n_fail = 0;

  divider_iterative #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s;
    logic [31:0] a, b, q, r;
    logic dz;
  } vec_t;
  vec_t v[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] aa, input logic [31:0] bb);
    start = 1; is_signed = s; a = aa; b = bb;
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish_op(input int inj);
    int j = 0, nb = 0;
    while (!done && j < 40) begin
      if (busy) nb++;
      start = (j == inj);
      if (j == inj) begin a = 50; b = 5; end
      @(negedge clk);
      j++;
    end
    start = 0;
    check("latency", j, 32);
    check("busy_cycles", nb, 32);
    check("busy_in_done", {31'b0, busy}, 0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] eq, input logic [31:0] er, input logic edz);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
  endtask

  initial begin
    v[0]  = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0};
    v[2]  = '{0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1};
    v[3]  = '{1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1};
    v[4]  = '{0, 32'd6, 32'd3, 32'd2, 32'd0, 0};
    v[6]  = '{0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0};
    v[9]  = '{1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1};
    v[10] = '{0, 32'd0, 32'd5, 32'd0, 32'd0, 0};
`ifdef DIVIDER_SIGNED_EN
    v[1]  = '{1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0};
    v[5]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0};
    v[7]  = '{1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0};
    v[8]  = '{1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 0};
`else
    v[1]  = '{1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 0};
    v[5]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0};
    v[7]  = '{1, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd7, 0};
    v[8]  = '{1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFF9, 0};
`endif
    reset = 1; start = 0; is_signed = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check_res("rst", 0, 0, 0);

    foreach (v[i]) begin
      launch(v[i].s, v[i].a, v[i].b);
      finish_op(-1);
      check_res($sformatf("vec%0d", i), v[i].q, v[i].r, v[i].dz);
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 0);
      check_res($sformatf("hold%0d", i), v[i].q, v[i].r, v[i].dz);
    end

    launch(0, 32'd9, 32'd4);
    finish_op(10);
    check_res("ignored", 2, 1, 0);
    launch(0, 32'd50, 32'd5);
    finish_op(-1);
    check_res("b2b", 10, 0, 0);
    @(negedge clk);
    check("b2b_pulse", {31'b0, done}, 0);

    launch(0, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check_res("abort", 0, 0, 0);
    begin
      int nd = 0;
      repeat (40) begin
        if (done || busy) nd++;
        @(negedge clk);
      end
      check("abort_no_done", nd, 0);
    end
    launch(0, 32'd100, 32'd7);
    finish_op(-1);
    check_res("fresh", 14, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
- Multi-cycle restoring integer divider; the division counterpart to the pipelined multiplier in the CPU execute stage (serves DIV/DIVU, results to HI/LO).
- Accepts one operand pair per start pulse and computes one quotient bit per cycle.
- Returns quotient and remainder with a start/busy/done handshake, so the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- is_signed  input  1  1 = signed (two's complement) divide, 0 = unsigned.
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; q/r/div_by_zero valid from this cycle.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- div_by_zero  output  1  set when the completed operation had b == 0.

Behaviour:
- One clock (clk); reset synchronous, active-high, names as given.
- Reset values:
  - state IDLE; busy 0, done 0, div_by_zero 0.
  - q 0, r 0; internal counter and working registers 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start = 1 at edge k:
  - Latch a, b and is_signed.
  - Store magnitudes (|a|, |b| when signed, else raw).
  - Record quotient sign (a[MSB] ^ b[MSB]) and remainder sign (a[MSB]), signed only.
  - Clear partial remainder; count = 0; go to RUN.
- RUN, each edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder (WIDTH+1-bit compare).
  - If non-negative, keep the difference and set quotient LSB to 1; else restore and set it to 0.
  - count increments. At the edge where count == WIDTH-1, write final q/r (with sign fix-up) and div_by_zero, then go to DONE.
- Latency:
  - With start at edge k, results are written at edge k+WIDTH (k+32).
  - done = 1 for exactly the cycle after that edge, i.e. WIDTH+1 cycles after start is sampled.
  - Latency is fixed and independent of operand values.
- busy = 1 in RUN only. done = 1 in DONE only.
- DONE always leaves after one cycle: to IDLE, or back to RUN if start is sampled there (back-to-back operations).
- q, r and div_by_zero hold their values until the next result write or reset.
- start while busy is ignored; the operands in flight are unaffected.
- Sign fix-up (signed mode):
  - q is negated if the quotient sign is 1.
  - r is negated if the dividend was negative (truncation toward zero, remainder takes the dividend's sign).
- Divide by zero (b == 0):
  - Full latency still elapses.
  - Result overrides the sign fix-up: q = all ones, r = original a, div_by_zero = 1.
- Signed overflow (a = most-negative, b = -1): q = most-negative value (wraps), r = 0, div_by_zero = 0.
- Reset mid-operation: at the reset edge the block returns to IDLE with all outputs at reset values. No done pulse is produced for the aborted operation.
- reset has priority over start in the same cycle.

Optional Feature:
- Macro DIVIDER_SIGNED_EN.
- Defined: is_signed is honoured as above.
- Undefined:
  - is_signed is ignored and every operation is unsigned.
  - No abs/negate logic is built.
  - The port remains present, so the interface is unchanged.

Test Plan:
- Unsigned 100 / 7, start at edge 0 -> busy cycles 1..32; done high only in cycle 33; q = 14, r = 2, div_by_zero = 0.
- Signed -7 / 2 (a = 0xFFFFFFF9, b = 0x00000002) -> q = 0xFFFFFFFD, r = 0xFFFFFFFF. Without DIVIDER_SIGNED_EN -> q = 0x7FFFFFFC, r = 0x00000001.
- a = 5, b = 0 (unsigned and signed) -> after 33 cycles q = 0xFFFFFFFF, r = 0x00000005, div_by_zero = 1. Next valid op 6 / 3 clears it: q = 2, r = 0, div_by_zero = 0.
- Signed 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0, div_by_zero = 0.
- start with 9 / 4, then start with 50 / 5 pulsed in cycle 10 while busy -> second request ignored; single done with q = 2, r = 1. start asserted in the done cycle with 50 / 5 -> done 33 cycles later with q = 10, r = 0.
- reset asserted in cycle 15 of an operation -> next cycle busy = 0, q = r = 0; no done pulse ever appears. A fresh start afterwards completes normally with the full 33-cycle latency.
